// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: timed PWDN / RESETB / XCLK bring-up, then an
// init request/done handshake with timeout-driven retries and fault reporting.
module cam_pwr_seq #(
  parameter int unsigned T_PWDN_US       = 1000,
  parameter int unsigned T_RST_US        = 1000,
  parameter int unsigned T_SETTLE_US     = 20000,
  parameter int unsigned INIT_TIMEOUT_US = 500000,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       clk_1us,
  input  logic       reset,
  input  logic       enable,
  input  logic       init_done,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       xclk_en,
  output logic       init_req,
  output logic       ready,
  output logic       fault,
  output logic [3:0] state_out,
  output logic [1:0] retry_cnt
);

  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_PWR_UP   = 4'd1,
    S_RST_HOLD = 4'd2,
    S_SETTLE   = 4'd3,
    S_INIT     = 4'd4,
    S_READY    = 4'd5,
    S_FAULT    = 4'd6
  } state_t;

  localparam logic [31:0] PWDN_LAST    = 32'(T_PWDN_US - 1);
  localparam logic [31:0] RST_LAST     = 32'(T_RST_US - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(T_SETTLE_US - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(INIT_TIMEOUT_US - 1);
  localparam logic [1:0]  RETRY_MAX    = 2'(MAX_RETRIES);

  state_t      state, state_nx;
  logic [1:0]  en_sync, done_sync;
  logic        en_s, done_s;
  logic [31:0] tick, tick_nx;
  logic        armed, armed_nx;
  logic [1:0]  retry_nx;
  logic        pwdn_nx, rst_n_nx, xclk_nx, req_nx, ready_nx, fault_nx;

  assign en_s      = en_sync[1];
  assign done_s    = done_sync[1];
  assign state_out = state;

  always_ff @(posedge clk_1us or negedge reset) begin
    if (!reset) begin
      en_sync   <= '0;
      done_sync <= '0;
    end else begin
      en_sync   <= {en_sync[0], enable};
      done_sync <= {done_sync[0], init_done};
    end
  end

  always_ff @(posedge clk_1us or negedge reset) begin
    if (!reset) begin
      state     <= S_OFF;
      tick      <= '0;
      armed     <= 1'b0;
      retry_cnt <= '0;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      xclk_en   <= 1'b0;
      init_req  <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      tick      <= tick_nx;
      armed     <= armed_nx;
      retry_cnt <= retry_nx;
      cam_pwdn  <= pwdn_nx;
      cam_rst_n <= rst_n_nx;
      xclk_en   <= xclk_nx;
      init_req  <= req_nx;
      ready     <= ready_nx;
      fault     <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    case (state)
      S_OFF: begin
        retry_nx = '0;
        if (en_s) state_nx = S_PWR_UP;
      end
      S_PWR_UP:   if (tick == PWDN_LAST)   state_nx = S_RST_HOLD;
      S_RST_HOLD: if (tick == RST_LAST)    state_nx = S_SETTLE;
      S_SETTLE:   if (tick == SETTLE_LAST) state_nx = S_INIT;
      S_INIT: begin
        // a completed handshake beats a timeout landing on the same cycle
        if (armed && done_s) begin
          state_nx = S_READY;
        end else if (tick == TIMEOUT_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_nx = retry_cnt + 2'd1;
            state_nx = S_RST_HOLD;
          end else begin
            state_nx = S_FAULT;
          end
        end
      end
      S_READY, S_FAULT: state_nx = state;
      default: begin
        state_nx = S_OFF;
        retry_nx = '0;
      end
    endcase

    if (!en_s) begin
      state_nx = S_OFF;
      retry_nx = '0;
    end

    tick_nx  = (state_nx != state) ? '0 : tick + 32'd1;
    // stale done from an earlier run must be seen low before it can complete INIT
    armed_nx = (state == S_INIT) && (state_nx == S_INIT) && (armed || !done_s);

    pwdn_nx  = 1'b1;
    rst_n_nx = 1'b0;
    xclk_nx  = 1'b0;
    req_nx   = 1'b0;
    ready_nx = 1'b0;
    fault_nx = 1'b0;
    case (state_nx)
      S_RST_HOLD: begin
        pwdn_nx = 1'b0;
        xclk_nx = 1'b1;
      end
      S_SETTLE: begin
        pwdn_nx  = 1'b0;
        xclk_nx  = 1'b1;
        rst_n_nx = 1'b1;
      end
      S_INIT: begin
        pwdn_nx  = 1'b0;
        xclk_nx  = 1'b1;
        rst_n_nx = 1'b1;
        req_nx   = 1'b1;
      end
      S_READY: begin
        pwdn_nx  = 1'b0;
        xclk_nx  = 1'b1;
        rst_n_nx = 1'b1;
        ready_nx = 1'b1;
      end
      S_FAULT: fault_nx = 1'b1;
      default: pwdn_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Self-checking bench for cam_pwr_seq: expected pins come from an offset-based
// timeline model (phase boundaries computed arithmetically from the dwell times).
module tb_cam_pwr_seq;

  localparam int TP  = 10;
  localparam int TR  = 5;
  localparam int TS  = 20;
  localparam int TO  = 50;
  localparam int MR  = 2;
  localparam int A0  = TP + TR + TS;       // first INIT entry offset
  localparam int PER = TO + TR + TS;       // INIT attempt plus retry re-bring-up
  localparam int FAULT_AT = A0 + MR * PER + TO;
  localparam int NEVER = MR + 1;

  logic       clk_1us = 1'b0;
  logic       reset, enable, init_done;
  logic       cam_pwdn, cam_rst_n, xclk_en, init_req, ready, fault;
  logic [3:0] state_out;
  logic [1:0] retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  cam_pwr_seq #(
    .T_PWDN_US(TP), .T_RST_US(TR), .T_SETTLE_US(TS),
    .INIT_TIMEOUT_US(TO), .MAX_RETRIES(MR)
  ) dut (
    .clk_1us(clk_1us), .reset(reset), .enable(enable), .init_done(init_done),
    .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .xclk_en(xclk_en),
    .init_req(init_req), .ready(ready), .fault(fault),
    .state_out(state_out), .retry_cnt(retry_cnt)
  );

  always #5 clk_1us = ~clk_1us;

  // {state, pwdn, rst_n, xclk_en, init_req, ready, fault, retry}
  function automatic logic [11:0] pack_st(input int st, input int r);
    logic [5:0] pins;
    case (st)
      0, 1:    pins = 6'b100000;
      2:       pins = 6'b001000;
      3:       pins = 6'b011000;
      4:       pins = 6'b011100;
      5:       pins = 6'b011010;
      6:       pins = 6'b100001;
      default: pins = 6'b000000;
    endcase
    return {st[3:0], pins, r[1:0]};
  endfunction

  // off: edges since PWR_UP entry; done completes at tick d of attempt k
  function automatic logic [11:0] expect_at(input int off, input int k, input int d,
                                            input int drop_off);
    int ready_at, r, a, w;
    if (off < 0 || off >= drop_off) return pack_st(0, 0);
    ready_at = (k <= MR) ? A0 + k * PER + d + 1 : (1 << 30);
    if (off >= ready_at) return pack_st(5, k);
    if (off >= FAULT_AT) return pack_st(6, MR);
    if (off < TP) return pack_st(1, 0);
    if (off < TP + TR) return pack_st(2, 0);
    if (off < A0) return pack_st(3, 0);
    r = off - A0;
    a = r / PER;
    w = r % PER;
    if (w < TO) return pack_st(4, a);
    if (w < TO + TR) return pack_st(2, a + 1);
    return pack_st(3, a + 1);
  endfunction

  function automatic logic [11:0] observed();
    return {state_out, cam_pwdn, cam_rst_n, xclk_en, init_req, ready, fault, retry_cnt};
  endfunction

  // Raises enable, plays done into attempt k at tick d, drops enable so that
  // OFF appears at offset drop_in (0 = a few cycles after the final state).
  task automatic run_seq(input string name, input int k, input int d, input int drop_in);
    int off, drop_off, end_off;
    logic [11:0] exp_v, got;
    end_off  = (k <= MR) ? A0 + k * PER + d + 5 : FAULT_AT + 4;
    drop_off = (drop_in > 0) ? drop_in : end_off;
    @(posedge clk_1us); #1;
    enable = 1'b1;
    off = -3;
    while (off < drop_off + 3) begin
      @(posedge clk_1us); #1;
      off++;
      exp_v = expect_at(off, k, d, drop_off);
      got   = observed();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL %s k=%0d d=%0d off=%0d got=%h exp=%h", name, k, d, off, got, exp_v);
      end
      if (k <= MR && off == A0 + k * PER + d - 2) init_done = 1'b1;
      if (off == drop_off - 3) enable = 1'b0;
    end
    init_done = 1'b0;
    repeat (3) @(posedge clk_1us);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; init_done = 1'b0;
    repeat (2) @(posedge clk_1us);
    #1;
    n_cmp++;
    if (observed() !== pack_st(0, 0)) begin
      n_bad++;
      $display("FAIL reset_hold got=%h exp=%h", observed(), pack_st(0, 0));
    end
    reset = 1'b1;
    repeat (3) @(posedge clk_1us);
    #1;
    n_cmp++;
    if (observed() !== pack_st(0, 0)) begin
      n_bad++;
      $display("FAIL reset_idle got=%h exp=%h", observed(), pack_st(0, 0));
    end
  endtask

  task automatic test_nominal();
    run_seq("nominal", 0, 6, 0);          // done raised 4 cycles after init_req
  endtask

  task automatic test_fault_retries();
    run_seq("fault_retries", NEVER, 0, 0);
  endtask

  task automatic test_enable_drop();
    run_seq("drop_settle", NEVER, 0, TP + TR + 10);
    run_seq("drop_ready", 0, 6, A0 + 7 + 3);
    run_seq("reenable", 1, 20, 0);
  endtask

  task automatic test_done_timeout();
    run_seq("done_at_timeout", 1, TO - 1, 0);
    run_seq("done_timeout_drop", 1, TO - 1, A0 + PER + TO);
    run_seq("done_at_last_timeout", 2, TO - 1, 0);
  endtask

  task automatic test_stale_done();
    int off, drop_off;
    logic [11:0] exp_v;
    drop_off = A0 + 18;
    init_done = 1'b1;
    repeat (3) @(posedge clk_1us);
    #1;
    enable = 1'b1;
    off = -3;
    while (off < drop_off + 3) begin
      @(posedge clk_1us); #1;
      off++;
      // one low cycle at A0+11 arms the handshake, READY lands at A0+14
      exp_v = expect_at(off, 0, 13, drop_off);
      n_cmp++;
      if (observed() !== exp_v) begin
        n_bad++;
        $display("FAIL stale_done off=%0d got=%h exp=%h", off, observed(), exp_v);
      end
      if (off == A0 + 10) init_done = 1'b0;
      if (off == A0 + 11) init_done = 1'b1;
      if (off == drop_off - 3) enable = 1'b0;
    end
    init_done = 1'b0;
    repeat (3) @(posedge clk_1us);
  endtask

  task automatic test_async_reset();
    logic [11:0] exp_v;
    @(posedge clk_1us); #1;
    enable = 1'b1;
    repeat (3 + TP + 2) @(posedge clk_1us);
    #1;
    n_cmp++;
    if (observed() !== pack_st(2, 0)) begin
      n_bad++;
      $display("FAIL areset_pre got=%h exp=%h", observed(), pack_st(2, 0));
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== pack_st(0, 0)) begin
      n_bad++;
      $display("FAIL areset_immediate got=%h exp=%h", observed(), pack_st(0, 0));
    end
    #2 reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk_1us); #1;
      exp_v = (e == 3) ? pack_st(1, 0) : pack_st(0, 0);
      n_cmp++;
      if (observed() !== exp_v) begin
        n_bad++;
        $display("FAIL areset_restart edge=%0d got=%h exp=%h", e, observed(), exp_v);
      end
    end
    enable = 1'b0;
    repeat (4) @(posedge clk_1us);
    #1;
    n_cmp++;
    if (observed() !== pack_st(0, 0)) begin
      n_bad++;
      $display("FAIL areset_off got=%h exp=%h", observed(), pack_st(0, 0));
    end
  endtask

  task automatic test_random();
    int k, d, end_off, drop;
    for (int t = 0; t < 25; t++) begin
      k = int'($urandom_range(0, NEVER));
      d = int'($urandom_range(1, TO - 1));
      end_off = (k <= MR) ? A0 + k * PER + d + 5 : FAULT_AT + 4;
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, end_off)) : 0;
      run_seq("random", k, d, drop);
    end
  endtask

  initial begin
    #5ms;
    n_bad++;
    $display("FAIL watchdog expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    test_reset();
    test_nominal();
    test_fault_retries();
    test_stale_done();
    test_enable_drop();
    test_done_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
